dac_iq_frame_ctrl: RTL

- Sequences one dual-channel PLB DAC port and shares its 10-bit data bus between the I and Q sample streams.
- Buffers paired I/Q samples in an internal FIFO, runs the DAC power-up and enable sequence, and interleaves I and Q onto the data pins with a matching DCLKIO select.
- Sits between the plb_dac register/stream logic and the S_* DAC pins. One instance per DAC (plb_dac_0, plb_dac_1).

---
 rtl/dac_iq_frame_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dac_iq_frame_ctrl.sv
// Sequencer for one dual-channel DAC port: buffers I/Q pairs, runs power-up/enable,
// and interleaves I then Q onto the shared data bus with a matching DCLKIO select.
//   state   | meaning
//   S_OFF   | powered down, bus parked at MID, FIFO flushed on entry
//   S_PWRUP | PWRDN released, outputs disabled, power-up timer running
//   S_RUN   | outputs enabled, one I/Q pair emitted per frame
//   S_STOP  | one trailing MID frame before returning to OFF
module dac_iq_frame_ctrl #(
    parameter int DATA_W       = 10,
    parameter int FIFO_DEPTH   = 16,
    parameter int PH_DIV       = 2,
    parameter int PWRUP_CYCLES = 1000
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          ctrl_enable,
    input  logic                          ctrl_format,
    input  logic                          wr_valid,
    input  logic [DATA_W-1:0]             wr_i,
    input  logic [DATA_W-1:0]             wr_q,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic                          busy,
    output logic [DATA_W-1:0]             dac_data,
    output logic                          dac_dclkio,
    output logic                          dac_pwrdn,
    output logic                          dac_openi,
    output logic                          dac_openq,
    output logic                          dac_format,
    output logic                          dac_pinmd,
    output logic                          dac_clkmd
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PH_W  = $clog2(2 * PH_DIV);
    localparam int CNT_W = $clog2(PWRUP_CYCLES + 1);

    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(2 * PH_DIV - 1);
    localparam logic [PH_W-1:0]   PH_HALF  = PH_W'(PH_DIV);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [AW:0]       LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] MID_OB   = DATA_W'(1) << (DATA_W - 1);

    typedef enum logic [1:0] {S_OFF, S_PWRUP, S_RUN, S_STOP} state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     pwr_cnt;
    logic [PH_W-1:0]      ph, ph_nx;
    logic [AW:0]          wptr, rptr;
    logic [2*DATA_W-1:0]  mem [FIFO_DEPTH];

    logic [DATA_W-1:0]    hold_i, hold_q, hold_i_nx, hold_q_nx;
    logic [DATA_W-1:0]    data_nx, mid_nx, head_i, head_q;
    logic                 dclk_nx, pwrdn_nx, open_nx, fmt_nx, unf_nx, busy_nx;
    logic                 last_ph, pwr_done, frame_start;
    logic                 push, pop, fifo_empty, fifo_clr;

    assign dac_pinmd  = 1'b1;
    assign dac_clkmd  = 1'b0;

    assign fifo_level = wptr - rptr;
    assign wr_ready   = (fifo_level != LVL_FULL);
    assign fifo_empty = (wptr == rptr);
    assign head_i     = mem[rptr[AW-1:0]][2*DATA_W-1:DATA_W];
    assign head_q     = mem[rptr[AW-1:0]][DATA_W-1:0];

    assign last_ph  = (ph == PH_LAST);
    assign pwr_done = (pwr_cnt == '0);
    assign ph_nx    = ((state == S_RUN || state == S_STOP) && !last_ph) ? ph + PH_W'(1) : '0;

    // A frame starts on RUN entry and on every in-RUN wrap; only then is the FIFO popped.
    assign frame_start = (state_nx == S_RUN) && (ph_nx == '0);
    assign push        = wr_valid & wr_ready;
    assign pop         = frame_start & ~fifo_empty;
    assign fifo_clr    = (state_nx == S_OFF) && (state != S_OFF);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) state <= S_OFF;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_OFF:   if (ctrl_enable) state_nx = S_PWRUP;
            S_PWRUP: begin
                if (!ctrl_enable)  state_nx = S_OFF;
                else if (pwr_done) state_nx = S_RUN;
            end
            S_RUN:   if (last_ph && !ctrl_enable) state_nx = S_STOP;
            S_STOP:  if (last_ph) state_nx = S_OFF;
            default: state_nx = S_OFF;
        endcase
    end

    always_comb begin
        fmt_nx    = (state == S_OFF && state_nx == S_PWRUP) ? ctrl_format : dac_format;
        mid_nx    = fmt_nx ? '0 : MID_OB;
        unf_nx    = (state == S_OFF && state_nx == S_PWRUP) ? 1'b0 : underflow;
        hold_i_nx = hold_i;
        hold_q_nx = hold_q;
        data_nx   = mid_nx;
        dclk_nx   = 1'b0;
        pwrdn_nx  = 1'b1;
        open_nx   = 1'b0;
        busy_nx   = (state_nx != S_OFF);
        case (state_nx)
            S_PWRUP: pwrdn_nx = 1'b0;
            S_RUN: begin
                pwrdn_nx = 1'b0;
                open_nx  = 1'b1;
                if (frame_start) begin
                    if (pop) begin
                        hold_i_nx = head_i;
                        hold_q_nx = head_q;
                        data_nx   = head_i;
                    end else begin
                        hold_i_nx = mid_nx;
                        hold_q_nx = mid_nx;
                        unf_nx    = 1'b1;
                    end
                end else begin
                    dclk_nx = (ph_nx >= PH_HALF);
                    data_nx = dclk_nx ? hold_q : hold_i;
                end
            end
            S_STOP: begin
                pwrdn_nx = 1'b0;
                open_nx  = 1'b1;
                dclk_nx  = (ph_nx >= PH_HALF);
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pwr_cnt <= '0;
            ph      <= '0;
        end else begin
            ph <= ph_nx;
            if (state == S_OFF && state_nx == S_PWRUP) pwr_cnt <= CNT_LOAD;
            else if (state == S_PWRUP && !pwr_done)    pwr_cnt <= pwr_cnt - CNT_W'(1);
        end
    end

    // Flush on OFF entry wins over a same-edge write.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (fifo_clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW + 1)'(1);
            if (pop)  rptr <= rptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push && !fifo_clr) mem[wptr[AW-1:0]] <= {wr_i, wr_q};
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            dac_data   <= '0;
            dac_dclkio <= 1'b0;
            dac_pwrdn  <= 1'b1;
            dac_openi  <= 1'b0;
            dac_openq  <= 1'b0;
            dac_format <= 1'b0;
            underflow  <= 1'b0;
            busy       <= 1'b0;
            hold_i     <= '0;
            hold_q     <= '0;
        end else begin
            dac_data   <= data_nx;
            dac_dclkio <= dclk_nx;
            dac_pwrdn  <= pwrdn_nx;
            dac_openi  <= open_nx;
            dac_openq  <= open_nx;
            dac_format <= fmt_nx;
            underflow  <= unf_nx;
            busy       <= busy_nx;
            hold_i     <= hold_i_nx;
            hold_q     <= hold_q_nx;
        end
    end

endmodule
